// File: rtl/vanity_pkg.sv
// ----------------------------------------------------------------------------
// vanity_pkg
// Shared types and constants for the vanity search sequencer.
//   state_t    : walk controller states (IDLE / RUN / DRAIN)
//   *_DEF      : default widths and FIFO depths
//   ptr_width  : pointer width for a FIFO of a given depth
// ----------------------------------------------------------------------------
package vanity_pkg;

  localparam int COORD_WIDTH_DEF = 256;
  localparam int CNT_WIDTH_DEF   = 64;
  localparam int TAG_DEPTH_DEF   = 4;
  localparam int MATCH_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Depths are powers of two, so the pointer is exactly clog2(depth) bits.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vanity_sync_fifo.sv
// ----------------------------------------------------------------------------
// vanity_sync_fifo
// Single-clock FIFO. A push while full is taken only when a pop happens in
// the same cycle; a pop while empty is ignored. pop_data shows the head entry
// (zero when empty).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : synchronous empty (wins over push/pop)
//   push, push_data : write request and data
//   pop             : remove head entry
//   pop_data        : head entry
//   full, empty     : status
//   count           : number of stored entries
// ----------------------------------------------------------------------------
module vanity_sync_fifo
  import vanity_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == {(PW+1){1'b0}});
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      cnt    <= {(PW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  // Head of queue, forced to zero when nothing is stored.
  always_comb begin
    if (empty) pop_data = {WIDTH{1'b0}};
    else       pop_data = mem[rd_ptr];
  end

endmodule

// File: rtl/vanity_search_sequencer.sv
// ----------------------------------------------------------------------------
// vanity_search_sequencer
// Walks the public-key adder from a seed point, tags each adder result with
// its iteration count, carries the tags through the hash/compare latency and
// queues matched iteration counts for readout.
// Optional feature macro: VANITY_ITER_LIMIT_EN (adds rx_limit / tx_limit_hit).
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   rx_start / rx_stop          : begin walk (IDLE only) / stop issuing and drain
//   rx_seed_x, rx_seed_y        : seed point
//   tx_adder_reset, tx_x, tx_y  : one-cycle adder start pulse and operand point
//   rx_adder_done, rx_adder_x/y : adder result (held until next start pulse)
//   rx_cmp_valid, rx_cmp_match  : compare result per issued point, in order
//   tx_match_valid/cnt, rx_match_ack : match FIFO head and pop handshake
//   tx_cnt, tx_busy             : completed iterations, walk active
//   tx_overflow, tx_tag_error   : sticky error flags
//   rx_limit, tx_limit_hit      : iteration limit (0 = none) and sticky hit flag
// ----------------------------------------------------------------------------
module vanity_search_sequencer
  import vanity_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int TAG_DEPTH   = TAG_DEPTH_DEF,
  parameter int MATCH_DEPTH = MATCH_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_start,
  input  logic                   rx_stop,
  input  logic [COORD_WIDTH-1:0] rx_seed_x,
  input  logic [COORD_WIDTH-1:0] rx_seed_y,
  output logic                   tx_adder_reset,
  output logic [COORD_WIDTH-1:0] tx_x,
  output logic [COORD_WIDTH-1:0] tx_y,
  input  logic                   rx_adder_done,
  input  logic [COORD_WIDTH-1:0] rx_adder_x,
  input  logic [COORD_WIDTH-1:0] rx_adder_y,
  input  logic                   rx_cmp_valid,
  input  logic                   rx_cmp_match,
  output logic                   tx_match_valid,
  output logic [CNT_WIDTH-1:0]   tx_match_cnt,
  input  logic                   rx_match_ack,
  output logic [CNT_WIDTH-1:0]   tx_cnt,
  output logic                   tx_busy,
  output logic                   tx_overflow,
  output logic                   tx_tag_error
`ifdef VANITY_ITER_LIMIT_EN
  ,
  input  logic [CNT_WIDTH-1:0]   rx_limit,
  output logic                   tx_limit_hit
`endif
);

  localparam int TAG_CW   = $clog2(TAG_DEPTH) + 1;
  localparam int MATCH_CW = $clog2(MATCH_DEPTH) + 1;
  localparam logic [TAG_CW-1:0] TAG_ONE = TAG_CW'(1);

  state_t                 state;
  logic                   tag_full, tag_empty, tag_pop, tag_flush;
  logic [TAG_CW-1:0]      tag_count;
  logic [CNT_WIDTH-1:0]   tag_head;
  logic                   match_full, match_empty, match_push, match_pop;
  logic [MATCH_CW-1:0]    match_count;
  logic                   accept, limit_reached, drain_done;
  logic [CNT_WIDTH-1:0]   cnt_next;

  assign tag_pop    = rx_cmp_valid && !tag_empty;
  assign tag_flush  = (state == IDLE) && rx_start;
  assign match_push = tag_pop && rx_cmp_match;
  assign match_pop  = rx_match_ack && !match_empty;
  assign cnt_next   = tx_cnt + 1'b1;

  // A held adder result is taken once per start pulse, and only when its tag
  // has room (a same-cycle tag pop frees the slot).
  assign accept = (state == RUN) && rx_adder_done && !tx_adder_reset &&
                  (!tag_full || tag_pop);

  // DRAIN ends as soon as the tag FIFO will be empty after this cycle.
  assign drain_done = (tag_count == {TAG_CW{1'b0}}) || ((tag_count == TAG_ONE) && tag_pop);

  assign tx_match_valid = (match_count != {MATCH_CW{1'b0}});

`ifdef VANITY_ITER_LIMIT_EN
  assign limit_reached = (rx_limit != {CNT_WIDTH{1'b0}}) && (cnt_next == rx_limit);
`else
  assign limit_reached = 1'b0;
`endif

  vanity_sync_fifo #(.WIDTH(CNT_WIDTH), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (tag_flush),
    .push      (accept),
    .push_data (tx_cnt),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  vanity_sync_fifo #(.WIDTH(CNT_WIDTH), .DEPTH(MATCH_DEPTH)) u_match_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (match_push),
    .push_data (tag_head),
    .pop       (match_pop),
    .pop_data  (tx_match_cnt),
    .full      (match_full),
    .empty     (match_empty),
    .count     (match_count)
  );

  // Walk controller: state, operand point, iteration count and start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tx_busy        <= 1'b0;
      tx_adder_reset <= 1'b0;
      tx_x           <= {COORD_WIDTH{1'b0}};
      tx_y           <= {COORD_WIDTH{1'b0}};
      tx_cnt         <= {CNT_WIDTH{1'b0}};
`ifdef VANITY_ITER_LIMIT_EN
      tx_limit_hit   <= 1'b0;
`endif
    end else begin
      tx_adder_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_start) begin
            tx_x           <= rx_seed_x;
            tx_y           <= rx_seed_y;
            tx_cnt         <= {CNT_WIDTH{1'b0}};
            tx_adder_reset <= 1'b1;
            tx_busy        <= 1'b1;
            state          <= RUN;
`ifdef VANITY_ITER_LIMIT_EN
            tx_limit_hit   <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            tx_x   <= rx_adder_x;
            tx_y   <= rx_adder_y;
            tx_cnt <= cnt_next;
            // A stop or limit on the accepting cycle still records the result
            // but launches no further adder work.
            if (rx_stop || limit_reached) state <= DRAIN;
            else                          tx_adder_reset <= 1'b1;
`ifdef VANITY_ITER_LIMIT_EN
            if (limit_reached) tx_limit_hit <= 1'b1;
`endif
          end else if (rx_stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      tx_tag_error <= 1'b0;
    end else begin
      if (rx_cmp_valid && tag_empty)                tx_tag_error <= 1'b1;
      if (match_push && match_full && !rx_match_ack) tx_overflow  <= 1'b1;
    end
  end

endmodule

// File: doc/vanity_search_sequencer.md
Name: vanity_search_sequencer

Overview:
- Parametrised successor to the vanity search loop controller. Drives the public-key adder walk from a seed point and counts iterations.
- Tags every adder result with its iteration count and carries the tags through the hash/compare latency in an in-flight tag FIFO.
- Queues matched iteration counts in a match FIFO, read through a valid/ack handshake.
- Adds start/stop/drain control, stall backpressure and sticky error flags. Sits between the external control wires and the adder / address_hash / vanity_compare chain.

Parameters:
COORD_WIDTH, 256, width of point coordinates x/y
CNT_WIDTH, 64, width of iteration counter and tags
TAG_DEPTH, 4, in-flight tag FIFO entries (power of 2, >=2)
MATCH_DEPTH, 8, match FIFO entries (power of 2, >=2)

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
rx_start  in  1  pulse: load seed and begin walk (accepted only in IDLE)
rx_stop  in  1  pulse: stop issuing work, drain
rx_seed_x, rx_seed_y  in  COORD_WIDTH  seed point
tx_adder_reset  out  1  one-cycle pulse: adder starts on tx_x/tx_y
tx_x, tx_y  out  COORD_WIDTH  current point to adder
rx_adder_done  in  1  adder result valid (held until next tx_adder_reset)
rx_adder_x, rx_adder_y  in  COORD_WIDTH  adder result
rx_cmp_valid  in  1  one-cycle pulse per compared hash, in issue order
rx_cmp_match  in  1  qualifies rx_cmp_valid
tx_match_valid  out  1  match FIFO non-empty
tx_match_cnt  out  CNT_WIDTH  head of match FIFO
rx_match_ack  in  1  pop head when tx_match_valid
tx_cnt  out  CNT_WIDTH  completed iterations
tx_busy  out  1  state != IDLE
tx_overflow  out  1  sticky: match dropped because match FIFO full
tx_tag_error  out  1  sticky: rx_cmp_valid while tag FIFO empty

Behaviour:
- Reset (sync, active-high, overrides everything): state IDLE; all outputs 0; both FIFOs empty; tx_cnt, tx_x, tx_y = 0.
- States: IDLE, RUN, DRAIN.
- IDLE + rx_start: next cycle tx_x/tx_y = seed, tx_cnt = 0, tag FIFO flushed, tx_adder_reset = 1 for exactly one cycle, state RUN. Match FIFO and sticky flags are kept.
- rx_start outside IDLE: ignored.
- RUN accept: rx_adder_done && !tx_adder_reset && (tag not full || tag pop this cycle).
  - tx_x/tx_y <= adder result; tag push = tx_cnt (value before increment); tx_cnt += 1, wraps modulo 2^CNT_WIDTH.
  - tx_adder_reset = 1 next cycle.
- Point for tag T = seed + (T+1)·G.
- Tag FIFO full with no pop: stall. No accept and no tx_adder_reset; adder_done stays high; accept in the first cycle space exists.
- rx_cmp_valid: pop tag. If rx_cmp_match, push the tag into the match FIFO. Tag FIFO empty: set tx_tag_error, push nothing.
- Match FIFO full with no ack in the same cycle: drop the match, set tx_overflow. Push + ack in the same cycle while full is legal and drops nothing.
- rx_stop in RUN (also in the same cycle as an accept; the accept still completes): state DRAIN, no further tx_adder_reset. If that accept scheduled a pulse, it is suppressed.
- DRAIN: adder_done ignored; cmp results still processed; tag FIFO empty -> IDLE.
- rx_stop in IDLE/DRAIN: no effect.
- Latency: accept -> tx_adder_reset 1 cycle; cmp pulse -> tx_match_valid 1 cycle.

Optional Feature:
VANITY_ITER_LIMIT_EN:
- Defined: adds ports rx_limit (in, CNT_WIDTH) and tx_limit_hit (out, 1, sticky, cleared on accepted rx_start).
- In RUN, an accept whose incremented tx_cnt equals rx_limit forces DRAIN and sets tx_limit_hit; that accept issues no tx_adder_reset.
- rx_limit = 0 means unlimited.
- Undefined: ports absent; walk runs until rx_stop.

Decomposition:
- Package vanity_pkg: state enum (IDLE/RUN/DRAIN), default width constants, clog2-derived pointer widths.
- Sub-module vanity_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count; same-cycle push+pop when full legal), instantiated for the tag FIFO and the match FIFO.

Test Plan:
- Seed (1,2), adder model returning x+1,y+1 after 5 cycles, no matches -> tx_adder_reset pulse per result; after 10 accepts tx_cnt=10, tx_x=11.
- Match on 3rd compare (tags 0,1,2) -> tx_match_valid with tx_match_cnt=2; ack -> valid drops next cycle.
- TAG_DEPTH=4, compare never responds -> exactly 4 accepts, then tx_adder_reset stays low with rx_adder_done high. One rx_cmp_valid -> 5th accept the same cycle.
- MATCH_DEPTH=8, 9 matches with no ack -> 8 entries 0..7 read back in order, tx_overflow=1. A 10th match pushed with an ack while full -> no drop.
- rx_stop with 3 tags pending -> no further adder pulses. tx_busy stays 1 until the 3rd rx_cmp_valid, then IDLE. rx_cmp_valid with tags empty -> tx_tag_error=1.
- VANITY_ITER_LIMIT_EN, rx_limit=5 -> tx_cnt stops at 5, tx_limit_hit=1, IDLE after drain. rx_start clears tx_limit_hit and tx_cnt.
